// File: rtl/sssp_ar_sched.sv
// sssp_ar_sched: round-robin arbiter that shares one AR channel between N_REQ sssp workers,
// splitting each range into bursts limited by MAX_BEATS and 4KB pages, with a credit cap on bursts in flight.
// Optional grant/stall counters are built when SSSP_AR_SCHED_STATS_EN is defined.
module sssp_ar_sched #(
  parameter int N_REQ           = 3,
  parameter int MAX_BEATS       = 64,
  parameter int MAX_OUTSTANDING = 8,
  localparam int ID_W  = $clog2(N_REQ),
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [16*N_REQ-1:0]   req_beats,
  input  logic [3*N_REQ-1:0]    req_size,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [31:0]           m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [ID_W-1:0]       m_arid,
  output logic                  m_arlast_chunk,
  input  logic                  m_rvalid,
  input  logic                  m_rready,
  input  logic                  m_rlast,
  output logic [32*N_REQ-1:0]   stat_grants,
  output logic [31:0]           stat_credit_stall
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [ID_W:0]      NREQ_V = (ID_W+1)'(N_REQ);
  localparam logic [16:0]        MAXB_V = 17'(MAX_BEATS);
  localparam logic [OUT_W-1:0]   MAXO_V = OUT_W'(MAX_OUTSTANDING);

  state_t               state, state_nxt;
  logic [ID_W-1:0]      rr_ptr, cur_id, pick_off, pick_id;
  logic [ID_W:0]        pick_sum;
  logic [N_REQ-1:0]     rot_valid;
  logic [2*N_REQ-1:0]   dbl_valid;
  logic                 pick_vld, grant, credit_ok, ar_hs, r_done, last_chunk;
  logic [31:0]          sel_addr, cur_addr;
  logic [15:0]          sel_beats, remaining;
  logic [2:0]           sel_size, cur_size;
  logic [OUT_W-1:0]     outstanding;
  logic [16:0]          room, chunk;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    logic [ID_W:0] inc;
    inc = {1'b0, id} + (ID_W+1)'(1);
    return (inc == NREQ_V) ? '0 : inc[ID_W-1:0];
  endfunction

  // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the winner, then mux its fields.
  always_comb begin
    dbl_valid = {req_valid, req_valid} >> rr_ptr;
    rot_valid = dbl_valid[N_REQ-1:0];
    pick_vld  = |rot_valid;
    pick_off  = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (rot_valid[k]) pick_off = ID_W'(k);
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    pick_id  = (pick_sum >= NREQ_V) ? ID_W'(pick_sum - NREQ_V) : pick_sum[ID_W-1:0];
    sel_addr  = '0;
    sel_beats = '0;
    sel_size  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_id == ID_W'(k)) begin
        sel_addr  = req_addr[32*k +: 32];
        sel_beats = req_beats[16*k +: 16];
        sel_size  = req_size[3*k +: 3];
      end
    end
  end

  // Current burst length: smallest of remaining beats, MAX_BEATS and beats left in the 4KB page.
  always_comb begin
    room  = {4'b0, 13'h1000 - {1'b0, cur_addr[11:0]}} >> cur_size;
    chunk = {1'b0, remaining};
    if (MAXB_V < chunk) chunk = MAXB_V;
    if (room < chunk)   chunk = room;
    last_chunk = (chunk == {1'b0, remaining});
  end

  // Next-state and handshake outputs; grants are suppressed while reset is held.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    m_arvalid = 1'b0;
    grant     = 1'b0;
    credit_ok = (outstanding < MAXO_V);
    case (state)
      IDLE: begin
        if (pick_vld && !rst) begin
          grant = 1'b1;
          for (int k = 0; k < N_REQ; k++) req_ready[k] = (pick_id == ID_W'(k));
          if (sel_beats != '0) state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        // credit_ok cannot drop while valid is up: outstanding only falls until the handshake
        m_arvalid = credit_ok;
        if (credit_ok && m_arready && last_chunk) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ar_hs  = m_arvalid & m_arready;
  assign r_done = m_rvalid & m_rready & m_rlast & (outstanding != '0);

  assign m_araddr       = (state == ISSUE) ? cur_addr : '0;
  assign m_arlen        = (state == ISSUE) ? 8'(chunk - 17'd1) : '0;
  assign m_arsize       = (state == ISSUE) ? cur_size : '0;
  assign m_arid         = (state == ISSUE) ? cur_id : '0;
  assign m_arlast_chunk = (state == ISSUE) & last_chunk;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the granted request, then walk address/remaining per issued burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      cur_size  <= '0;
    end else if (grant) begin
      cur_addr  <= sel_addr;
      remaining <= sel_beats;
      cur_size  <= sel_size;
      cur_id    <= pick_id;
      if (sel_beats == '0) rr_ptr <= next_id(pick_id);
    end else if (ar_hs) begin
      cur_addr  <= cur_addr + (32'(chunk) << cur_size);
      remaining <= remaining - chunk[15:0];
      if (last_chunk) rr_ptr <= next_id(cur_id);
    end
  end

  // Bursts in flight: +1 per AR handshake, -1 per accepted rlast, floor at zero.
  always_ff @(posedge clk) begin
    if (rst)                    outstanding <= '0;
    else if (ar_hs && !r_done)  outstanding <= outstanding + OUT_W'(1);
    else if (!ar_hs && r_done)  outstanding <= outstanding - OUT_W'(1);
  end

`ifdef SSSP_AR_SCHED_STATS_EN
  logic [31:0] grant_cnt [N_REQ];
  logic [31:0] stall_cnt;

  // Saturating per-requester grant counters and credit-stall cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) grant_cnt[k] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (req_ready[k] && grant_cnt[k] != '1) grant_cnt[k] <= grant_cnt[k] + 32'd1;
      end
      if (state == ISSUE && !credit_ok && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // Flatten counters onto the stat bus.
  always_comb begin
    stat_grants = '0;
    for (int k = 0; k < N_REQ; k++) stat_grants[32*k +: 32] = grant_cnt[k];
  end
  assign stat_credit_stall = stall_cnt;
`else
  assign stat_grants       = '0;
  assign stat_credit_stall = '0;
`endif

endmodule
